// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: PC width, reset address,
// FSM state encodings and the branch displacement helper.
package pc_sequencer_pkg;

    localparam int unsigned PC_W = 16;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_WAIT_ACK = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_HALTED   = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

    // Word offset to byte displacement. Only the low 14 offset bits survive
    // the shift into a 16-bit address space, so the sign bits above them
    // cannot change the wrapped result.
    function automatic logic [PC_W-1:0] branch_disp(input logic [13:0] word_off);
        return {word_off, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jr, j/jal, taken branch or sequential.
// Also flags a misaligned register jump target. No state, so it can be
// reused by a pipelined fetch unit.
module pc_next_calc
    import pc_sequencer_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic            Jump,
    input  logic            JumpFromReg,
    input  logic            Branch,
    input  logic            Zero,
    input  logic [25:0]     JumpOffset,
    input  logic [15:0]     BranchOffset,
    input  logic [PC_W-1:0] ReadData1,
    output logic [PC_W-1:0] next_pc,
    output logic            misalign
);

    logic [PC_W-1:0] seq_pc_s;
    logic            unused_bits_s;

    assign seq_pc_s = pc + 16'd4;

    // Jump target bits above [13:0] and branch offset bits above [13:0]
    // shift out of the 16-bit address space.
    assign unused_bits_s = ^{JumpOffset[25:14], BranchOffset[15:14]};

    // Priority select of the next PC; jr target alignment is checked here.
    always_comb begin
        next_pc  = seq_pc_s;
        misalign = 1'b0;
        if (Jump && JumpFromReg) begin
            next_pc  = ReadData1;
            misalign = (ReadData1[1:0] != 2'b00);
        end else if (Jump) begin
            next_pc = {JumpOffset[13:0], 2'b00};
        end else if (Branch && Zero) begin
            next_pc = seq_pc_s + branch_disp(BranchOffset[13:0]);
        end else begin
            next_pc = seq_pc_s;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle instruction sequencer: owns the PC, runs the fetch handshake
// with instruction memory, and commits the next PC when execution ends.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned     ACK_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            instr_valid,
    input  logic            exec_done,
    input  logic            Jump,
    input  logic            JumpFromReg,
    input  logic            Branch,
    input  logic            Zero,
    input  logic [25:0]     JumpOffset,
    input  logic [15:0]     BranchOffset,
    input  logic [PC_W-1:0] ReadData1,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            fault,
    output logic [2:0]      state_o
);

    // Last counter value allowed in WAIT_ACK before giving up.
    localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 32'd1);

    state_e          state_r;
    state_e          state_nxt_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_nxt_s;
    logic [15:0]     cnt_r;
    logic [15:0]     cnt_nxt_s;
    logic            imem_req_r;
    logic            instr_valid_r;
    logic            fault_r;
    logic [PC_W-1:0] calc_pc_s;
    logic            calc_misalign_s;

    pc_next_calc u_pc_next_calc (
        .pc           (pc_r),
        .Jump         (Jump),
        .JumpFromReg  (JumpFromReg),
        .Branch       (Branch),
        .Zero         (Zero),
        .JumpOffset   (JumpOffset),
        .BranchOffset (BranchOffset),
        .ReadData1    (ReadData1),
        .next_pc      (calc_pc_s),
        .misalign     (calc_misalign_s)
    );

    // Next-state, next-PC and timeout counter decisions.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_FETCH: begin
                state_nxt_s = ST_WAIT_ACK;
                cnt_nxt_s   = 16'd0;
            end
            ST_WAIT_ACK: begin
                if (imem_ack) begin
                    state_nxt_s = ST_DECODE;
                end else if (cnt_r == ACK_LAST) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            ST_DECODE: begin
                state_nxt_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (!exec_done) begin
                    state_nxt_s = ST_EXEC;
                end else if (halt) begin
                    state_nxt_s = ST_HALTED;
                end else if (calc_misalign_s) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_FETCH;
                    pc_nxt_s    = calc_pc_s;
                end
            end
            ST_HALTED: begin
                state_nxt_s = ST_HALTED;
            end
            ST_FAULT: begin
                state_nxt_s = ST_FAULT;
            end
            default: begin
                // Unreachable encodings park in FAULT.
                state_nxt_s = ST_FAULT;
            end
        endcase
    end

    // State, PC, counter and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_FETCH;
            pc_r          <= RESET_PC;
            cnt_r         <= 16'd0;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            cnt_r         <= cnt_nxt_s;
            imem_req_r    <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_WAIT_ACK);
            instr_valid_r <= (state_nxt_s == ST_DECODE);
            fault_r       <= (state_nxt_s == ST_FAULT);
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr_valid = instr_valid_r;
    assign fault       = fault_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_r + 16'd4;
    assign state_o     = state_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (ACK_TIMEOUT = 4).
module tb_pc_sequencer;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        exec_done;
    logic        Jump;
    logic        JumpFromReg;
    logic        Branch;
    logic        Zero;
    logic [25:0] JumpOffset;
    logic [15:0] BranchOffset;
    logic [15:0] ReadData1;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] pc_plus4;
    logic        fault;
    logic [2:0]  state_o;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int cyc        = 0;
    int dec_cyc    = 0;
    int prev_dec   = 0;

    pc_sequencer #(
        .RESET_PC    (16'h0000),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .instr_valid  (instr_valid),
        .exec_done    (exec_done),
        .Jump         (Jump),
        .JumpFromReg  (JumpFromReg),
        .Branch       (Branch),
        .Zero         (Zero),
        .JumpOffset   (JumpOffset),
        .BranchOffset (BranchOffset),
        .ReadData1    (ReadData1),
        .halt         (halt),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fault        (fault),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        Jump = 1'b0; JumpFromReg = 1'b0; Branch = 1'b0; Zero = 1'b0;
        JumpOffset = 26'd0; BranchOffset = 16'd0; ReadData1 = 16'd0; halt = 1'b0;
    endtask

    // One complete instruction starting in FETCH: ack immediately, exec_done
    // on the first EXEC cycle, then check the resulting state and PC.
    task automatic run_instr(input string tag, input logic [15:0] exp_addr,
                             input logic jmp, input logic jfr, input logic br, input logic zr,
                             input logic [25:0] joff, input logic [15:0] boff,
                             input logic [15:0] rd1, input logic hlt,
                             input logic [2:0] exp_st, input logic [15:0] exp_pc);
        check_value({tag, "_fetch_state"}, 32'(state_o), 32'(S_FETCH));
        check_value({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
        step();
        check_value({tag, "_req"}, 32'(imem_req), 32'd1);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check_value({tag, "_ivalid"}, 32'(instr_valid), 32'd1);
        prev_dec = dec_cyc;
        dec_cyc  = cyc;
        Jump = jmp; JumpFromReg = jfr; Branch = br; Zero = zr;
        JumpOffset = joff; BranchOffset = boff; ReadData1 = rd1; halt = hlt;
        step();
        check_value({tag, "_ivalid_off"}, 32'(instr_valid), 32'd0);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        clear_ctrl();
        check_value({tag, "_state"}, 32'(state_o), 32'(exp_st));
        check_value({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    endtask

    task automatic check_reset_state(input string tag);
        check_value({tag, "_state"}, 32'(state_o), 32'(S_FETCH));
        check_value({tag, "_pc"}, 32'(pc), 32'h0000);
        check_value({tag, "_fault"}, 32'(fault), 32'd0);
        check_value({tag, "_req"}, 32'(imem_req), 32'd0);
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; exec_done = 1'b0;
        clear_ctrl();
        step();
        step();
        check_reset_state("rst");
        check_value("rst_ivalid", 32'(instr_valid), 32'd0);
        check_value("rst_pc_plus4", 32'(pc_plus4), 32'h0004);
        reset = 1'b0;

        // Sequential flow with 4-cycle cadence.
        run_instr("seq0", 16'h0000, 0, 0, 0, 0, 26'd0, 16'd0, 16'd0, 0, S_FETCH, 16'h0004);
        run_instr("seq1", 16'h0004, 0, 0, 0, 0, 26'd0, 16'd0, 16'd0, 0, S_FETCH, 16'h0008);
        check_value("cadence1", 32'(dec_cyc - prev_dec), 32'd4);
        run_instr("seq2", 16'h0008, 0, 0, 0, 0, 26'd0, 16'd0, 16'd0, 0, S_FETCH, 16'h000C);
        check_value("cadence2", 32'(dec_cyc - prev_dec), 32'd4);
        run_instr("seq3", 16'h000C, 0, 0, 0, 0, 26'd0, 16'd0, 16'd0, 0, S_FETCH, 16'h0010);

        // Branches: taken backwards, then not taken.
        run_instr("br_taken", 16'h0010, 0, 0, 1, 1, 26'd0, 16'hFFFE, 16'd0, 0, S_FETCH, 16'h000C);
        run_instr("seq4", 16'h000C, 0, 0, 0, 0, 26'd0, 16'd0, 16'd0, 0, S_FETCH, 16'h0010);
        run_instr("br_nt", 16'h0010, 0, 0, 1, 0, 26'd0, 16'hFFFE, 16'd0, 0, S_FETCH, 16'h0014);

        // Jumps; Branch alongside Jump must lose.
        run_instr("j20", 16'h0014, 1, 0, 0, 0, 26'h0000008, 16'd0, 16'd0, 0, S_FETCH, 16'h0020);
        run_instr("j400", 16'h0020, 1, 0, 1, 1, 26'h0000100, 16'h0010, 16'd0, 0, S_FETCH, 16'h0400);
        run_instr("jr20", 16'h0400, 1, 1, 0, 0, 26'h0000100, 16'd0, 16'h0020, 0, S_FETCH, 16'h0020);
        run_instr("jr1234", 16'h0020, 1, 1, 0, 0, 26'h0000100, 16'd0, 16'h1234, 0, S_FETCH, 16'h1234);
        run_instr("jfr_only", 16'h1234, 0, 1, 0, 0, 26'd0, 16'd0, 16'h5555, 0, S_FETCH, 16'h1238);

        // Wrap-around of the sequential PC.
        run_instr("jrfffc", 16'h1238, 1, 1, 0, 0, 26'd0, 16'd0, 16'hFFFC, 0, S_FETCH, 16'hFFFC);
        check_value("wrap_pc_plus4", 32'(pc_plus4), 32'h0000);
        run_instr("wrap", 16'hFFFC, 0, 0, 0, 0, 26'd0, 16'd0, 16'd0, 0, S_FETCH, 16'h0000);

        // Misaligned register target faults with PC held.
        run_instr("jr20b", 16'h0000, 1, 1, 0, 0, 26'd0, 16'd0, 16'h0020, 0, S_FETCH, 16'h0020);
        run_instr("jr_mis", 16'h0020, 1, 1, 0, 0, 26'd0, 16'd0, 16'h1236, 0, S_FAULT, 16'h0020);
        check_value("jr_mis_fault", 32'(fault), 32'd1);
        check_value("jr_mis_req", 32'(imem_req), 32'd0);
        step();
        check_value("fault_sticky", 32'(state_o), 32'(S_FAULT));

        // Reset out of FAULT.
        reset = 1'b1;
        step();
        check_reset_state("rst_fault");
        reset = 1'b0;

        // Ack timeout: four WAIT_ACK cycles without ack, then FAULT.
        for (int i = 0; i < 4; i++) step();
        check_value("to_wait4", 32'(state_o), 32'(S_WAIT));
        step();
        check_value("to_state", 32'(state_o), 32'(S_FAULT));
        check_value("to_fault", 32'(fault), 32'd1);

        // Ack on the timeout cycle wins.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check_value("late_ack_state", 32'(state_o), 32'(S_DECODE));
        check_value("late_ack_fault", 32'(fault), 32'd0);
        check_value("late_ack_ivalid", 32'(instr_valid), 32'd1);
        step();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check_value("late_ack_pc", 32'(pc), 32'h0004);

        // Reset in the middle of EXEC.
        step();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        step();
        check_value("exec_reached", 32'(state_o), 32'(S_EXEC));
        reset = 1'b1;
        step();
        check_reset_state("rst_exec");
        reset = 1'b0;

        // Reset during WAIT_ACK.
        run_instr("pre_wait", 16'h0000, 0, 0, 0, 0, 26'd0, 16'd0, 16'd0, 0, S_FETCH, 16'h0004);
        step();
        check_value("wait_reached", 32'(state_o), 32'(S_WAIT));
        reset = 1'b1;
        step();
        check_reset_state("rst_wait");
        reset = 1'b0;

        // Halt: terminal, no fetch requests, PC held.
        run_instr("halt", 16'h0000, 1, 0, 0, 0, 26'h0000040, 16'd0, 16'd0, 1, S_HALTED, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            step();
            check_value("halt_req", 32'(imem_req), 32'd0);
            check_value("halt_state", 32'(state_o), 32'(S_HALTED));
        end
        check_value("halt_pc", 32'(pc), 32'h0000);
        check_value("halt_fault", 32'(fault), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multicycle instruction-sequencing controller that owns the program counter and drives the next-address selection: sequential, branch, jump/jal, or jr.
- Issues fetch requests to instruction memory with a req/ack handshake.
- Holds the datapath in a one-instruction-at-a-time cadence.
- Commits the next PC only when the datapath signals that execution has finished.
- Sits between instruction memory, the decoder/control unit and the register file read port.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
ACK_TIMEOUT, 255, max cycles spent in WAIT_ACK before FAULT (1..65535)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  16  fetch address, equals pc while imem_req=1
imem_ack  input  1  instruction memory has data this cycle
instr_valid  output  1  one-cycle pulse: fetched instruction is latchable by the decoder
exec_done  input  1  datapath finished the current instruction; control inputs valid this cycle
Jump  input  1  j / jal / jr
JumpFromReg  input  1  jr (qualifies Jump)
Branch  input  1  conditional branch
Zero  input  1  ALU zero flag
JumpOffset  input  26  jump target field
BranchOffset  input  16  signed branch offset in words
ReadData1  input  16  register jump target
halt  input  1  current instruction is halt, sampled with exec_done
pc  output  16  current PC
pc_plus4  output  16  pc+4 mod 2^16, used as the jal link value
fault  output  1  sticky error flag
state_o  output  3  current FSM state, for debug

Behaviour:
- Reset values:
  - pc=RESET_PC; state=FETCH; fault=0.
  - imem_req=0, instr_valid=0; timeout counter=0.
  - Reset has priority over every other input, in any state, including mid-handshake.
- States and encoding:
  - FETCH=0, WAIT_ACK=1, DECODE=2, EXEC=3, HALTED=4, FAULT=5.
  - Outputs are registered and derived from state.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Next state WAIT_ACK; counter is cleared.
- WAIT_ACK:
  - imem_req stays 1.
  - If imem_ack=1: go to DECODE.
  - Otherwise the counter increments. When counter==ACK_TIMEOUT-1 with no ack: go to FAULT.
  - An ack arriving on the timeout cycle wins; the block goes to DECODE.
- DECODE: instr_valid=1 for exactly this cycle, imem_req=0; go to EXEC.
- EXEC: waits indefinitely for exec_done. On exec_done, resolution is evaluated in priority order:
  1. halt=1: go to HALTED, pc unchanged.
  2. Jump & JumpFromReg: if ReadData1[1:0]!=0, go to FAULT with pc unchanged; else pc<=ReadData1, go to FETCH.
  3. Jump: pc<={JumpOffset[13:0],2'b00}, go to FETCH.
  4. Branch & Zero: pc<=pc+4+(sign_extend(BranchOffset)<<2), truncated to 16 bits (wrap-around). Go to FETCH.
  5. Else: pc<=pc+4, wraps from 16'hFFFC to 16'h0000. Go to FETCH.
- Don't-care inputs:
  - JumpFromReg without Jump is ignored.
  - Branch with Jump: Jump wins.
  - Control inputs outside EXEC, or without exec_done, are ignored.
- HALTED / FAULT:
  - Terminal until reset; pc is held.
  - fault=1 in FAULT only.
  - imem_req=0.
- pc_plus4 is combinational from pc and is valid in every state.
- Latency:
  - Minimum 4 cycles per instruction: FETCH, WAIT_ACK (ack same cycle), DECODE, EXEC (done same cycle).
  - The new pc is visible the cycle after exec_done.

Decomposition:
- Shared package/include (parameters.v): state encodings, the RESET_PC default, and the PC width constant 16.
- One natural sub-module: pc_next_calc. Purely combinational; computes the next pc and a misalign flag from pc and the control inputs. It is reusable by a future pipelined fetch unit.
- The FSM and timeout counter stay in pc_sequencer.

Test Plan:
- Reset, then ack immediately and exec_done with no control each instruction → imem_addr sequence 0x0000, 0x0004, 0x0008; instr_valid pulses once per instruction, 4 cycles apart.
- pc=0x0010, Branch=1, Zero=1, BranchOffset=0xFFFE → pc=0x000C. Same stimulus with Zero=0 → pc=0x0014.
- pc=0x0020, Jump=1, JumpOffset=26'h0000100 → pc=0x0400. Adding JumpFromReg=1, ReadData1=0x1234 → pc=0x1234. ReadData1=0x1236 → FAULT, fault=1, pc=0x0020.
- pc=0xFFFC, sequential → pc=0x0000 (wrap).
- Hold imem_ack=0 with ACK_TIMEOUT=4 → FAULT after 4 WAIT_ACK cycles. Ack on the 4th cycle → DECODE, no fault.
- Assert reset during WAIT_ACK and during EXEC → next cycle state=FETCH, pc=RESET_PC, fault=0. halt with exec_done → HALTED, imem_req stays 0 for 20 cycles.
